if_stage_loadable: RTL and testbench
====================================

IF_STAGE_LOADABLE -- requirements
Module: if_stage_loadable

Interface
REQ-001 Parameters SHALL be: NB_DATA, 32, instruction/PC width; NB_ADDR, 8, word-address bits (depth 2^NB_ADDR); HALT_WORD, 32'hFFFF_FFFF, halt encoding.
REQ-002 Ports SHALL be: i_clk  in  1  single clock, rising edge; i_reset  in  1  reset, asynchronous, active-high.
REQ-003 i_enable  in  1  global step/run enable; low freezes all state except memory load.
REQ-004 i_start  in  1  one-cycle pulse: begin execution at PC 0.
REQ-005 i_load_en  in  1; i_load_addr  in  NB_ADDR; i_load_data  in  NB_DATA  program-memory write port.
REQ-006 i_stall  in  1  hazard stall; i_flush  in  1  squash IF/ID contents.
REQ-007 i_pc_src  in  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 register jump.
REQ-008 i_branch_addr, i_jump_addr, i_jr_addr  in  NB_DATA each  redirect targets.
REQ-009 o_pc  out  NB_DATA  current PC; o_pc_4  out  NB_DATA  PC+4 of instruction in IF/ID; o_instruction  out  NB_DATA  IF/ID instruction.
REQ-010 o_valid  out  1  IF/ID holds real instruction; o_halt  out  1  halted; o_state  out  2  FSM state.

Function
REQ-011 FSM SHALL have states IDLE=00, RUN=01, HALT=10; 11 unreachable, decoded as IDLE.
REQ-012 Memory SHALL be 2^NB_ADDR x NB_DATA, synchronous write, combinational read; word index = o_pc[NB_ADDR+1:2] (PC wraps modulo depth x 4).
REQ-013 Writes SHALL occur on i_load_en in IDLE or HALT regardless of i_enable; writes in RUN SHALL be ignored.
REQ-014 IDLE/HALT + i_start + i_enable: next state RUN, PC<=0, IF/ID<=NOP (0), o_valid<=0, o_halt<=0.
REQ-015 "Advance" SHALL mean state RUN, i_enable=1, i_stall=0.
REQ-016 On advance with fetched word != HALT_WORD: IF/ID<={mem[PC], PC+4}, o_valid<=1, PC<=selected target.
REQ-017 Selected target: 00 PC+4, 01 i_branch_addr, 10 i_jump_addr, 11 i_jr_addr; bits [1:0] forced to 0.
REQ-018 PC arithmetic SHALL be modulo 2^NB_DATA; 32'hFFFF_FFFC+4 = 0.
REQ-019 i_stall=1 in RUN (i_flush=0): PC and IF/ID hold.
REQ-020 i_flush=1 with i_enable=1 in RUN: IF/ID<=NOP, o_valid<=0, PC<=selected target, overriding i_stall and halt detection.
REQ-021 On advance with fetched word == HALT_WORD: IF/ID captures it with o_valid=1, PC holds, next state HALT, o_halt=1 from next cycle.
REQ-022 In HALT with i_enable=1: IF/ID<=NOP, o_valid<=0 each cycle; PC holds; i_stall/i_flush/i_pc_src ignored.
REQ-023 In IDLE: PC and IF/ID hold; o_valid=0.
REQ-024 i_start with i_load_en same cycle: write commits; first RUN fetch (next cycle) sees new word.
REQ-025 i_start in RUN SHALL be ignored.
REQ-026 i_enable=0: PC, IF/ID, FSM hold; i_start ignored.
REQ-027 Latency: instruction at PC appears on o_instruction one cycle after the advance edge.

Reset
REQ-028 i_reset=1 SHALL immediately force: state IDLE, o_pc=0, o_pc_4=0, o_instruction=0, o_valid=0, o_halt=0.
REQ-029 Reset mid-RUN or mid-HALT SHALL behave identically; memory contents SHALL be retained across reset.
REQ-030 After reset release, outputs hold reset values until i_start.

Verification
REQ-031 Load 0x20010005@0, 0x20020007@1, HALT_WORD@2; start, pc_src=00 -> o_instruction 0x20010005, 0x20020007, 0xFFFFFFFF on successive cycles, o_pc_4 4,8,12, o_halt=1 next, o_pc stays 8.
REQ-032 RUN at PC 0x10, pc_src=01, branch_addr=0x41 -> o_pc=0x40 next cycle; jr_addr=0x80 with 11 -> o_pc=0x80.
REQ-033 Stall 3 cycles at PC 0x8 -> o_pc=0x8 and IF/ID unchanged 3 cycles; stall+flush same cycle -> o_valid=0, PC takes target.
REQ-034 i_reset pulse mid-RUN, PC 0x1C -> outputs 0 at once, state IDLE; restart re-fetches unchanged memory from 0.
REQ-035 Load in RUN to addr 0 -> mem[0] unchanged; i_enable=0 for 2 cycles in RUN -> PC, o_instruction frozen.
REQ-036 NB_ADDR=4: PC 0x40 fetches word 0; PC 0xFFFFFFFC with pc_src=00 -> next PC 0.

Source files
------------

// File: rtl/if_stage_loadable.sv
// ---------------------------------------------------------------------------
// if_stage_loadable
//   Instruction-fetch stage with a loadable program memory and a small
//   IDLE / RUN / HALT controller.
//
//   Ports
//     i_clk, i_reset        clock (rising edge), async active-high reset
//     i_enable              global step/run enable (memory load ignores it)
//     i_start               pulse: start execution at PC 0 (from IDLE/HALT)
//     i_load_en/addr/data   program-memory write port (IDLE/HALT only)
//     i_stall, i_flush      hazard stall / squash of the IF/ID register
//     i_pc_src              next-PC select: 00 PC+4, 01 branch, 10 jump,
//                           11 register jump
//     i_branch_addr, i_jump_addr, i_jr_addr   redirect targets
//     o_pc                  current PC
//     o_pc_4, o_instruction IF/ID register contents
//     o_valid               IF/ID holds a real instruction
//     o_halt                stage is halted
//     o_state               controller state (00 IDLE, 01 RUN, 10 HALT)
//
//   A NOP in IF/ID is instruction 0 with o_pc_4 0 and o_valid 0.
// ---------------------------------------------------------------------------
module if_stage_loadable #(
  parameter int                   NB_DATA   = 32,
  parameter int                   NB_ADDR   = 8,
  parameter logic [NB_DATA-1:0]   HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_start,
  input  logic               i_load_en,
  input  logic [NB_ADDR-1:0] i_load_addr,
  input  logic [NB_DATA-1:0] i_load_data,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [1:0]         i_pc_src,
  input  logic [NB_DATA-1:0] i_branch_addr,
  input  logic [NB_DATA-1:0] i_jump_addr,
  input  logic [NB_DATA-1:0] i_jr_addr,
  output logic [NB_DATA-1:0] o_pc,
  output logic [NB_DATA-1:0] o_pc_4,
  output logic [NB_DATA-1:0] o_instruction,
  output logic               o_valid,
  output logic               o_halt,
  output logic [1:0]         o_state
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  localparam int                 DEPTH     = 2 ** NB_ADDR;
  localparam logic [NB_DATA-1:0] PC_STEP   = NB_DATA'(4);
  localparam logic [NB_DATA-1:0] WORD_MASK = ~(NB_DATA'(3));

  logic [NB_DATA-1:0] mem [0:DEPTH-1];

  logic [1:0]         state;
  logic [NB_DATA-1:0] pc;
  logic [NB_DATA-1:0] pc_4_q;
  logic [NB_DATA-1:0] instr_q;
  logic               valid_q;

  logic               is_run;
  logic               is_halt;
  logic               start_ok;
  logic [NB_DATA-1:0] pc_plus_4;
  logic [NB_DATA-1:0] target_raw;
  logic [NB_DATA-1:0] pc_target;
  logic [NB_DATA-1:0] fetched;

  // State 11 is unreachable; anything that is not RUN or HALT acts as IDLE.
  assign is_run   = (state == ST_RUN);
  assign is_halt  = (state == ST_HALT);
  assign start_ok = i_enable && i_start && !is_run;

  assign pc_plus_4 = pc + PC_STEP;   // wraps modulo 2^NB_DATA
  assign fetched   = mem[pc[NB_ADDR+1:2]];

  always_comb begin
    target_raw = pc_plus_4;
    case (i_pc_src)
      2'b01:   target_raw = i_branch_addr;
      2'b10:   target_raw = i_jump_addr;
      2'b11:   target_raw = i_jr_addr;
      default: target_raw = pc_plus_4;
    endcase
  end

  // Targets are always word aligned.
  assign pc_target = target_raw & WORD_MASK;

  // Program memory: not reset, so a program survives an i_reset pulse.
  // Loading is only allowed while nothing is being fetched.
  always_ff @(posedge i_clk) begin
    if (i_load_en && !is_run) begin
      mem[i_load_addr] <= i_load_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      pc      <= '0;
      pc_4_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (i_enable) begin
      if (start_ok) begin
        state   <= ST_RUN;
        pc      <= '0;
        pc_4_q  <= '0;
        instr_q <= '0;
        valid_q <= 1'b0;
      end else begin
        case (state)
          ST_RUN: begin
            // Flush wins over both stall and halt detection.
            if (i_flush) begin
              pc_4_q  <= '0;
              instr_q <= '0;
              valid_q <= 1'b0;
              pc      <= pc_target;
            end else if (!i_stall) begin
              pc_4_q  <= pc_plus_4;
              instr_q <= fetched;
              valid_q <= 1'b1;
              if (fetched == HALT_WORD) begin
                state <= ST_HALT;       // PC stays on the halt word
              end else begin
                pc    <= pc_target;
              end
            end
          end
          ST_HALT: begin
            pc_4_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
          end
          default: begin
            // IDLE: everything holds until a start.
          end
        endcase
      end
    end
  end

  assign o_pc          = pc;
  assign o_pc_4        = pc_4_q;
  assign o_instruction = instr_q;
  assign o_valid       = valid_q;
  assign o_halt        = is_halt;
  assign o_state       = state;

endmodule

// File: tb/tb_if_stage_loadable.sv
module tb_if_stage_loadable;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        enable, start, load_en, stall, flush;
  logic [7:0]  load_addr;
  logic [31:0] load_data, br, jmp, jr;
  logic [1:0]  pc_src;

  logic [31:0] pc, pc_4, instr;
  logic        valid, halt;
  logic [1:0]  state;

  logic [31:0] q_pc, q_pc_4, q_instr;
  logic        q_valid, q_halt;
  logic [1:0]  q_state;

  if_stage_loadable #(.NB_DATA(32), .NB_ADDR(8), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(enable), .i_start(start),
    .i_load_en(load_en), .i_load_addr(load_addr), .i_load_data(load_data),
    .i_stall(stall), .i_flush(flush), .i_pc_src(pc_src),
    .i_branch_addr(br), .i_jump_addr(jmp), .i_jr_addr(jr),
    .o_pc(pc), .o_pc_4(pc_4), .o_instruction(instr),
    .o_valid(valid), .o_halt(halt), .o_state(state)
  );

  // Small-memory instance shares all inputs; only checked in its own test.
  if_stage_loadable #(.NB_DATA(32), .NB_ADDR(4), .HALT_WORD(32'hFFFF_FFFF)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_enable(enable), .i_start(start),
    .i_load_en(load_en), .i_load_addr(load_addr[3:0]), .i_load_data(load_data),
    .i_stall(stall), .i_flush(flush), .i_pc_src(pc_src),
    .i_branch_addr(br), .i_jump_addr(jmp), .i_jr_addr(jr),
    .o_pc(q_pc), .o_pc_4(q_pc_4), .o_instruction(q_instr),
    .o_valid(q_valid), .o_halt(q_halt), .o_state(q_state)
  );

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en   = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en, st, stl, fl;
    logic [1:0]  src;
    logic [31:0] br, jmp, jr;
    logic [31:0] e_pc, e_instr;
    logic        e_valid;
    logic [1:0]  e_state;
  } vec_t;

  vec_t tbl [17];

  initial begin
    // Memory image: [0]=0x20010005 [1]=0x20020007 [n]=0x10000000+n otherwise
    //                  en st stl fl src  br     jmp          jr     e_pc   e_instr       v  state
    tbl[0]  = '{1'b1,1'b1,1'b0,1'b0,2'b00,32'h0, 32'h0,        32'h0, 32'h00,32'h00000000,1'b0,2'b01};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,2'b00,32'h0, 32'h0,        32'h0, 32'h04,32'h20010005,1'b1,2'b01};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,2'b10,32'h0, 32'h10,       32'h0, 32'h10,32'h20020007,1'b1,2'b01};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,2'b01,32'h41,32'h0,        32'h0, 32'h40,32'h10000004,1'b1,2'b01};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,2'b11,32'h0, 32'h0,        32'h80,32'h80,32'h10000010,1'b1,2'b01};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,2'b10,32'h0, 32'h8,        32'h0, 32'h08,32'h10000020,1'b1,2'b01};
    tbl[6]  = '{1'b1,1'b0,1'b1,1'b0,2'b10,32'h0, 32'h44,       32'h0, 32'h08,32'h10000020,1'b1,2'b01};
    tbl[7]  = '{1'b1,1'b0,1'b1,1'b0,2'b00,32'h0, 32'h0,        32'h0, 32'h08,32'h10000020,1'b1,2'b01};
    tbl[8]  = '{1'b1,1'b0,1'b1,1'b0,2'b01,32'h4C,32'h0,        32'h0, 32'h08,32'h10000020,1'b1,2'b01};
    tbl[9]  = '{1'b1,1'b0,1'b1,1'b1,2'b10,32'h0, 32'h1C,       32'h0, 32'h1C,32'h00000000,1'b0,2'b01};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0,2'b01,32'h40,32'h0,        32'h0, 32'h1C,32'h00000000,1'b0,2'b01};
    tbl[11] = '{1'b0,1'b1,1'b0,1'b0,2'b00,32'h0, 32'h0,        32'h0, 32'h1C,32'h00000000,1'b0,2'b01};
    tbl[12] = '{1'b1,1'b1,1'b0,1'b0,2'b00,32'h0, 32'h0,        32'h0, 32'h20,32'h10000007,1'b1,2'b01};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b0,2'b10,32'h0, 32'h60,       32'h0, 32'h20,32'h10000007,1'b1,2'b01};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b0,2'b00,32'h0, 32'h0,        32'h0, 32'h20,32'h10000007,1'b1,2'b01};
    tbl[15] = '{1'b1,1'b0,1'b0,1'b1,2'b00,32'h0, 32'h0,        32'h0, 32'h24,32'h00000000,1'b0,2'b01};
    tbl[16] = '{1'b1,1'b0,1'b0,1'b0,2'b00,32'h0, 32'h0,        32'h0, 32'h28,32'h10000009,1'b1,2'b01};
  end

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; enable = 1'b0; start = 1'b0; load_en = 1'b0; stall = 1'b0; flush = 1'b0;
    load_addr = '0; load_data = '0; pc_src = 2'b00; br = '0; jmp = '0; jr = '0;
    repeat (2) step();
    rst = 1'b0;
    step();

    check("reset_pc",    pc,    32'h0);
    check("reset_pc_4",  pc_4,  32'h0);
    check("reset_instr", instr, 32'h0);
    check("reset_valid", valid, 32'h0);
    check("reset_halt",  halt,  32'h0);
    check("reset_state", state, 32'h0);

    // Loads with enable low still commit.
    load(8'd0, 32'h20010005);
    load(8'd1, 32'h20020007);
    load(8'd2, HALT);
    for (int i = 3; i < 64; i++) load(8'(i), 32'h10000000 + 32'(i));
    check("idle_hold_pc",    pc,    32'h0);
    check("idle_hold_state", state, 32'h0);

    // Straight-line run into the halt word.
    enable = 1'b1; start = 1'b1; step(); start = 1'b0;
    check("start_state", state, 32'h1);
    check("start_valid", valid, 32'h0);
    step();
    check("run1_instr", instr, 32'h20010005);
    check("run1_pc_4",  pc_4,  32'h4);
    check("run1_pc",    pc,    32'h4);
    step();
    check("run2_instr", instr, 32'h20020007);
    check("run2_pc_4",  pc_4,  32'h8);
    step();
    check("halt_instr", instr, HALT);
    check("halt_pc_4",  pc_4,  32'hC);
    check("halt_valid", valid, 32'h1);
    check("halt_pc",    pc,    32'h8);
    check("halt_flag",  halt,  32'h1);
    check("halt_state", state, 32'h2);
    step();
    check("halted_instr", instr, 32'h0);
    check("halted_valid", valid, 32'h0);
    check("halted_pc",    pc,    32'h8);
    check("halted_flag",  halt,  32'h1);

    // Writes are accepted in HALT; replace the halt word.
    load(8'd2, 32'h10000002);

    for (int i = 0; i < 17; i++) begin
      enable = tbl[i].en; start = tbl[i].st; stall = tbl[i].stl; flush = tbl[i].fl;
      pc_src = tbl[i].src; br = tbl[i].br; jmp = tbl[i].jmp; jr = tbl[i].jr;
      step();
      check($sformatf("vec%0d_pc", i),    pc,    tbl[i].e_pc);
      check($sformatf("vec%0d_instr", i), instr, tbl[i].e_instr);
      check($sformatf("vec%0d_valid", i), valid, 32'(tbl[i].e_valid));
      check($sformatf("vec%0d_state", i), state, 32'(tbl[i].e_state));
    end
    enable = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0;

    // Load attempted in RUN must be dropped.
    pc_src = 2'b10; jmp = 32'h0;
    load(8'd0, 32'hDEADBEEF);
    check("runload_instr", instr, 32'h1000000A);
    check("runload_pc",    pc,    32'h0);
    pc_src = 2'b00;
    step();
    check("runload_mem0", instr, 32'h20010005);

    // Asynchronous reset mid-run at PC 0x1C.
    pc_src = 2'b10; jmp = 32'h1C;
    step();
    check("prerst_pc", pc, 32'h1C);
    pc_src = 2'b00;
    rst = 1'b1;
    #1;
    check("async_rst_pc",    pc,    32'h0);
    check("async_rst_pc_4",  pc_4,  32'h0);
    check("async_rst_instr", instr, 32'h0);
    check("async_rst_valid", valid, 32'h0);
    check("async_rst_state", state, 32'h0);
    step();
    rst = 1'b0;
    step();
    step();
    check("postrst_pc",    pc,    32'h0);
    check("postrst_state", state, 32'h0);
    start = 1'b1; step(); start = 1'b0;
    check("restart_state", state, 32'h1);
    step();
    check("restart_instr", instr, 32'h20010005);
    check("restart_pc",    pc,    32'h4);

    // Start and load in the same cycle: first fetch sees the new word.
    rst = 1'b1; step(); rst = 1'b0;
    start = 1'b1; load_en = 1'b1; load_addr = 8'd0; load_data = 32'h2003000A;
    step();
    start = 1'b0; load_en = 1'b0;
    step();
    check("startload_instr", instr, 32'h2003000A);

    // NB_ADDR=4 instance: address wrap and PC wrap.
    rst = 1'b1; step(); rst = 1'b0;
    load(8'd0,  32'hA5A50000);
    load(8'd15, 32'hA5A5000F);
    start = 1'b1; step(); start = 1'b0;
    pc_src = 2'b10; jmp = 32'h40;
    step();
    check("n4_jump_pc", q_pc, 32'h40);
    jmp = 32'hFFFF_FFFC;
    step();
    check("n4_wrap_fetch", q_instr, 32'hA5A50000);
    check("n4_top_pc",     q_pc,    32'hFFFF_FFFC);
    pc_src = 2'b00;
    step();
    check("n4_top_instr", q_instr, 32'hA5A5000F);
    check("n4_top_pc_4",  q_pc_4,  32'h0);
    check("n4_pc_wrap",   q_pc,    32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
